upsample_2x: RTL and testbench

Streaming 2x nearest-neighbour upsampler, the inverse of the 2:1 decimating stage on the same valid/ready pixel interface. An IN_COLS x IN_ROWS raster-order input frame becomes a (2·IN_COLS) x (2·IN_ROWS) output frame:
- each input pixel is emitted twice horizontally;
- each input line is emitted twice vertically, the repeat replayed from an internal line buffer.

It sits after the downsampler, or after any stage producing a reduced-resolution raster stream, and restores full resolution.

---
 rtl/upsample_pkg.sv | 17 +
 rtl/upsample_line_buf.sv | 26 ++
 rtl/upsample_2x.sv | 118 +++++++++++
 tb/tb_upsample_2x.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared types and width helpers for the 2x nearest-neighbour upsampler.
package upsample_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        REPLAY = 1'b1
    } mode_e;

    function automatic int col_w(input int in_cols);
        return $clog2(in_cols);
    endfunction

    function automatic int row_w(input int in_rows);
        return $clog2(in_rows);
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// One-line pixel store: synchronous write, asynchronous read, no reset.
module upsample_line_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_COLS    = 16,
    parameter int COL_W      = 4
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [COL_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [COL_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [IN_COLS];

    // Line storage write port
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/upsample_2x.sv
// Streaming 2x nearest-neighbour upsampler (valid/ready in and out).
// Define UPSAMPLE_EOL_EN to add the data_out_eol end-of-line output.
module upsample_2x
    import upsample_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_COLS    = 16,
    parameter int IN_ROWS    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    output logic                  data_in_ready,
    output logic                  data_out_valid,
    output logic [DATA_WIDTH-1:0] data_out_data,
    input  logic                  data_out_ready
`ifdef UPSAMPLE_EOL_EN
    ,
    output logic                  data_out_eol
`endif
);

    localparam int COL_W = col_w(IN_COLS);
    localparam int ROW_W = row_w(IN_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);

    mode_e             mode_q, mode_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              phase_q, phase_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              buf_we_s;
    logic              ofire_s;
    logic [DATA_WIDTH-1:0] buf_rdata_s;

    upsample_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_COLS    (IN_COLS),
        .COL_W      (COL_W)
    ) u_line_buf (
        .CLK   (CLK),
        .we    (buf_we_s),
        .waddr (col_q),
        .wdata (data_in_data),
        .raddr (col_q),
        .rdata (buf_rdata_s)
    );

    // Handshake outputs: LIVE passes the input through, REPLAY reads the buffer
    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_data  = '0;
        if (RESET) begin
            data_in_ready  = 1'b0;
            data_out_valid = 1'b0;
        end else if (mode_q == LIVE) begin
            data_out_valid = data_in_valid;
            data_out_data  = data_in_data;
            data_in_ready  = data_out_ready & phase_q;
        end else begin
            data_out_valid = 1'b1;
            data_out_data  = buf_rdata_s;
        end
    end

    assign ofire_s = data_out_valid & data_out_ready;

    // Counter and mode next-state; phase 0 of LIVE captures the pixel for replay
    always_comb begin
        mode_d   = mode_q;
        col_d    = col_q;
        phase_d  = phase_q;
        row_d    = row_q;
        buf_we_s = 1'b0;
        if (ofire_s) begin
            if (!phase_q) begin
                phase_d  = 1'b1;
                buf_we_s = (mode_q == LIVE);
            end else begin
                phase_d = 1'b0;
                col_d   = col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    if (mode_q == LIVE) begin
                        mode_d = REPLAY;
                    end else begin
                        mode_d = LIVE;
                        row_d  = row_q + 1'b1;
                    end
                end else begin
                    mode_d = mode_q;
                end
            end
        end else begin
            buf_we_s = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q  <= LIVE;
            col_q   <= '0;
            phase_q <= 1'b0;
            row_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            row_q   <= row_d;
        end
    end

`ifdef UPSAMPLE_EOL_EN
    assign data_out_eol = data_out_valid & (col_q == COL_LAST) & phase_q;
`endif

endmodule

// File: tb/tb_upsample_2x.sv
// Directed self-checking bench for upsample_2x with IN_COLS=4, IN_ROWS=2.
module tb_upsample_2x;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          data_in_valid;
    logic [DW-1:0] data_in_data;
    logic          data_in_ready;
    logic          data_out_valid;
    logic [DW-1:0] data_out_data;
    logic          data_out_ready;
`ifdef UPSAMPLE_EOL_EN
    logic          data_out_eol;
    logic          obs_eol;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] src_mem [128];
    int            src_k;

    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_in_ready;

    int exp_t1 [32] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1, 2, 2, 3, 3, 4, 4,
                        5, 5, 6, 6, 7, 7, 8, 8, 5, 5, 6, 6, 7, 7, 8, 8};
    int rdy_t1 [32] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    upsample_2x #(
        .DATA_WIDTH (DW),
        .IN_COLS    (4),
        .IN_ROWS    (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .data_in_valid  (data_in_valid),
        .data_in_data   (data_in_data),
        .data_in_ready  (data_in_ready),
        .data_out_valid (data_out_valid),
        .data_out_data  (data_out_data),
        .data_out_ready (data_out_ready)
`ifdef UPSAMPLE_EOL_EN
        ,
        .data_out_eol   (data_out_eol)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle starting just after a rising edge; sample before the next edge.
    task automatic run_cycle(input logic rdy, input logic vld);
        data_out_ready = rdy;
        data_in_valid  = vld;
        data_in_data   = src_mem[src_k];
        #3;
        obs_valid    = data_out_valid;
        obs_data     = data_out_data;
        obs_in_ready = data_in_ready;
`ifdef UPSAMPLE_EOL_EN
        obs_eol      = data_out_eol;
`endif
        if (vld && data_in_ready) src_k++;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        repeat (cycles) @(posedge CLK);
        #1;
        RESET = 1'b0;
        src_k = 0;
    endtask

    initial begin
        int exp_v;
        int n_out;
        int exp_q [96];
        int idx;

        RESET          = 1'b1;
        data_in_valid  = 1'b1;
        data_in_data   = 16'h0001;
        data_out_ready = 1'b1;
        src_k          = 0;
        for (int i = 0; i < 128; i++) src_mem[i] = DW'(i + 1);
        #1;
        check_eq("rst_out_valid", {31'd0, data_out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, data_in_ready}, 32'd0);
        do_reset(2);

        // Two full frames at full rate: 2x pattern, ready cadence, no bubble at wrap
        for (int c = 0; c < 64; c++) begin
            run_cycle(1'b1, 1'b1);
            exp_v = exp_t1[c % 32] + 8 * (c / 32);
            check_eq($sformatf("t1_valid[%0d]", c), {31'd0, obs_valid}, 32'd1);
            check_eq($sformatf("t1_data[%0d]", c), {16'd0, obs_data}, 32'(exp_v));
            check_eq($sformatf("t1_in_ready[%0d]", c), {31'd0, obs_in_ready}, 32'(rdy_t1[c % 32]));
`ifdef UPSAMPLE_EOL_EN
            check_eq($sformatf("t1_eol[%0d]", c), {31'd0, obs_eol}, {31'd0, (c % 8) == 7});
`endif
        end
        check_eq("t1_consumed", 32'(src_k), 32'd16);

        // Stall mid-REPLAY at col 2, phase 1 (output index 13 of the frame)
        do_reset(1);
        for (int c = 0; c < 13; c++) run_cycle(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, 1'b1);
            check_eq($sformatf("stall_valid[%0d]", c), {31'd0, obs_valid}, 32'd1);
            check_eq($sformatf("stall_data[%0d]", c), {16'd0, obs_data}, 32'd3);
            check_eq($sformatf("stall_in_ready[%0d]", c), {31'd0, obs_in_ready}, 32'd0);
        end
        run_cycle(1'b1, 1'b1);
        check_eq("stall_resume_p1", {16'd0, obs_data}, 32'd3);
        run_cycle(1'b1, 1'b1);
        check_eq("stall_next_p0", {16'd0, obs_data}, 32'd4);
        run_cycle(1'b1, 1'b1);
        check_eq("stall_next_p1", {16'd0, obs_data}, 32'd4);
        run_cycle(1'b1, 1'b1);
        check_eq("stall_live_row1", {16'd0, obs_data}, 32'd5);
        check_eq("stall_live_row1_rdy", {31'd0, obs_in_ready}, 32'd0);

        // Reset pulse in LIVE at col 1, phase 1
        do_reset(1);
        for (int c = 0; c < 3; c++) run_cycle(1'b1, 1'b1);
        RESET = 1'b1;
        run_cycle(1'b1, 1'b1);
        check_eq("rstp_out_valid", {31'd0, obs_valid}, 32'd0);
        check_eq("rstp_in_ready", {31'd0, obs_in_ready}, 32'd0);
        RESET = 1'b0;
        src_k = 0;
        for (int i = 0; i < 8; i++) src_mem[i] = DW'(16'h00A1 + i);
        run_cycle(1'b1, 1'b1);
        check_eq("rstp_first_p0", {16'd0, obs_data}, 32'h00A1);
        check_eq("rstp_first_rdy0", {31'd0, obs_in_ready}, 32'd0);
        run_cycle(1'b1, 1'b1);
        check_eq("rstp_first_p1", {16'd0, obs_data}, 32'h00A1);
        check_eq("rstp_first_rdy1", {31'd0, obs_in_ready}, 32'd1);
        run_cycle(1'b1, 1'b1);
        check_eq("rstp_second", {16'd0, obs_data}, 32'h00A2);

        // Random ready (30%) and input gaps over three frames against a reference stream
        do_reset(1);
        for (int i = 0; i < 24; i++) src_mem[i] = DW'($urandom_range(0, 65535));
        for (int i = 24; i < 128; i++) src_mem[i] = 16'hDEAD;
        idx = 0;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 2; r++)
                for (int rep = 0; rep < 2; rep++)
                    for (int c = 0; c < 4; c++)
                        for (int p = 0; p < 2; p++) begin
                            exp_q[idx] = int'(src_mem[f * 8 + r * 4 + c]);
                            idx++;
                        end
        n_out = 0;
        for (int cyc = 0; cyc < 4000 && n_out < 96; cyc++) begin
            logic rdy;
            logic vld;
            rdy = ($urandom_range(0, 9) < 3);
            vld = ($urandom_range(0, 9) < 7) && (src_k < 24);
            run_cycle(rdy, vld);
            if (obs_valid && rdy) begin
                check_eq($sformatf("rand_data[%0d]", n_out), {16'd0, obs_data}, 32'(exp_q[n_out]));
`ifdef UPSAMPLE_EOL_EN
                check_eq($sformatf("rand_eol[%0d]", n_out), {31'd0, obs_eol}, {31'd0, (n_out % 8) == 7});
`endif
                n_out++;
            end
        end
        check_eq("rand_out_count", 32'(n_out), 32'd96);
        check_eq("rand_in_count", 32'(src_k), 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
